// File: rtl/uart_bus_bridge.sv
// rtl/uart_bus_bridge.sv - UART command frames to single register bus transactions
module uart_bus_bridge #(
  parameter int CLK_DIV      = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [15:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        busy,
  output logic        err
);
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLK_DIV;
  localparam int TO_W     = $clog2(TO_LIMIT);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] R_ACK  = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_BAD  = 2'd2;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  // receiver
  logic             rx_s1, rx_s2, rx_d;
  logic             rx_busy;
  logic [DIV_W-1:0] rx_cnt;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_tick, rx_valid, rx_ferr;

  // transmitter
  logic             tx_busy;
  logic [DIV_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [8:0]       tx_shift;
  logic             tx_done, tx_start;
  logic [7:0]       tx_byte;
  logic [1:0]       tx_sel;

  // control
  logic [2:0]       state;
  logic             cmd_wr;
  logic [1:0]       byte_cnt;
  logic [31:0]      rdata_q;
  logic [1:0]       resp_kind;
  logic [1:0]       resp_idx;
  logic             resp_last;
  logic [TO_W-1:0]  to_cnt;
  logic             to_hit, bad_cmd, overrun;

  assign rx_tick  = rx_busy && (rx_bit == 4'd0 ? rx_cnt == HALF_LAST : rx_cnt == DIV_LAST);
  assign rx_valid = rx_tick && rx_bit == 4'd9 && rx_s2;
  assign rx_ferr  = rx_tick && rx_bit == 4'd9 && !rx_s2;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receive byte: start-bit midpoint recheck, then one sample per bit period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= 4'd0;
      rx_shift <= 8'h00;
    end else if (!rx_busy) begin
      if (rx_d && !rx_s2) begin
        rx_busy <= 1'b1;
        rx_cnt  <= '0;
        rx_bit  <= 4'd0;
      end
    end else if (rx_tick) begin
      rx_cnt <= '0;
      if (rx_bit == 4'd0) begin
        if (rx_s2) rx_busy <= 1'b0;
        else       rx_bit  <= 4'd1;
      end else if (rx_bit == 4'd9) begin
        rx_busy <= 1'b0;
      end else begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 4'd1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1'b1;
    end
  end

  assign tx_done  = tx_busy && tx_cnt == DIV_LAST && tx_bit == 4'd9;
  assign resp_last = resp_idx == ((resp_kind == R_READ) ? 2'd3 : 2'd0);
  // A new byte may be loaded in the last stop-bit cycle so bytes run back to back
  assign tx_start = (state == S_RESP) && (!tx_busy || (tx_done && !resp_last));

  // Pick the response byte being loaded: current index when idle, next one at stop end
  always_comb begin
    tx_sel = tx_busy ? resp_idx + 2'd1 : resp_idx;
    case (resp_kind)
      R_READ: begin
        case (tx_sel)
          2'd0:    tx_byte = rdata_q[31:24];
          2'd1:    tx_byte = rdata_q[23:16];
          2'd2:    tx_byte = rdata_q[15:8];
          default: tx_byte = rdata_q[7:0];
        endcase
      end
      R_BAD:   tx_byte = 8'h3F;
      default: tx_byte = 8'h4B;
    endcase
  end

  // Transmit 10-bit frames; uart_tx is a register so it is glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_shift <= 9'h1FF;
    end else if (tx_start) begin
      uart_tx  <= 1'b0;
      tx_busy  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      tx_shift <= {1'b1, tx_byte};
    end else if (tx_busy) begin
      if (tx_cnt == DIV_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          uart_tx <= 1'b1;
        end else begin
          uart_tx  <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // The inter-byte timer only advances while the receiver is hunting, so a byte in flight never expires it
  assign to_hit  = (state == S_ADDR || state == S_DATA) && !rx_valid && !rx_busy && to_cnt == TO_LAST;
  assign bad_cmd = rx_valid && state == S_IDLE && rx_shift != CMD_WR && rx_shift != CMD_RD;
  assign overrun = rx_valid && (state == S_BUS || state == S_RESP);

  // All error causes merge into one registered pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= rx_ferr || bad_cmd || to_hit || overrun;
  end

  // Command sequencer: collect frame, run one bus access, send the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_wr    <= 1'b0;
      byte_cnt  <= 2'd0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 32'h0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      rdata_q   <= 32'h0;
      resp_kind <= R_ACK;
      resp_idx  <= 2'd0;
      busy      <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            busy     <= 1'b1;
            byte_cnt <= 2'd0;
            to_cnt   <= '0;
            resp_idx <= 2'd0;
            if (rx_shift == CMD_WR || rx_shift == CMD_RD) begin
              cmd_wr <= (rx_shift == CMD_WR);
              state  <= S_ADDR;
            end else begin
              resp_kind <= R_BAD;
              state     <= S_RESP;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == S_ADDR) begin
              bus_addr <= {bus_addr[7:0], rx_shift};
              if (byte_cnt == 2'd1) begin
                byte_cnt <= 2'd0;
                state    <= cmd_wr ? S_DATA : S_BUS;
              end
            end else begin
              bus_wdata <= {bus_wdata[23:0], rx_shift};
              if (byte_cnt == 2'd3) state <= S_BUS;
            end
          end else if (rx_ferr || to_hit) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (!rx_busy) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_BUS: begin
          if (!bus_we && !bus_re) begin
            bus_we <= cmd_wr;
            bus_re <= !cmd_wr;
          end else if (bus_ready) begin
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            if (!cmd_wr) rdata_q <= bus_rdata;
            resp_kind <= cmd_wr ? R_ACK : R_READ;
            resp_idx  <= 2'd0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_done) begin
            if (resp_last) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              resp_idx <= resp_idx + 2'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- UART-side bus initiator: receives command frames from an external host over UART and issues single read/write transactions on the SoC register bus.
- Drives the same we/re/addr/wdata/rdata style bus that peripherals such as the UART controller respond to, adding a ready handshake.
- Returns an ack byte or read data over UART.
- Used for debug/bring-up register access without CPU involvement.

Parameters:
- CLK_DIV, 868: clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- TIMEOUT_BITS, 32: inter-byte timeout in bit periods while a frame is partially received.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- uart_rx  in  1  serial input from host, idle high, asynchronous to clk.
- uart_tx  out  1  serial output to host, idle high.
- bus_addr  out  16  transaction address.
- bus_wdata  out  32  write data.
- bus_we  out  1  write request, held until bus_ready.
- bus_re  out  1  read request, held until bus_ready.
- bus_rdata  in  32  read data, valid in the cycle bus_ready is high.
- bus_ready  in  1  target completes the transaction this cycle.
- busy  out  1  high from the first command byte until the response is fully sent.
- err  out  1  one-cycle pulse on framing error, timeout, overrun, or bad command.

Behaviour:
- Reset values: uart_tx=1, bus_we=0, bus_re=0, bus_addr=0, bus_wdata=0, busy=0, err=0. The FSM returns to IDLE and any in-flight TX or RX byte is abandoned immediately; uart_tx goes high asynchronously with rst.
- RX engine:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts the bit counter. The start bit is re-sampled at CLK_DIV/2; if it is high, treat it as a glitch, ignore it, and return to hunting.
  - Data bits (LSB first) and the stop bit are sampled every CLK_DIV cycles after the start-bit midpoint.
  - Stop bit = 0 is a framing error: discard the byte, pulse err, abort the frame, and return to IDLE with no response.
  - A good byte produces a one-cycle rx_valid to the FSM in the cycle the stop bit is sampled.
- Frame format (multi-byte fields MSB first):
  - Write: 0x57, addr[15:8], addr[7:0], d[31:24], d[23:16], d[15:8], d[7:0].
  - Read: 0x52, addr[15:8], addr[7:0].
- FSM states:
  - IDLE: on rx_valid, 0x57 or 0x52 latches the command, sets busy, and goes to ADDR. Any other byte pulses err and queues response 0x3F ("?"), going to RESP.
  - ADDR: collects 2 bytes into bus_addr. Then a write goes to DATA and a read goes to BUS.
  - DATA: collects 4 bytes into bus_wdata, shifting in from the LSB end. Then goes to BUS.
  - BUS: bus_we or bus_re is asserted in the cycle after entering BUS and held until bus_ready=1 is sampled. The request deasserts in the next cycle. On a read, bus_rdata is captured in the cycle bus_ready is high. bus_ready in the same cycle the request first rises is legal: the transaction completes after one cycle. There is no bus timeout; the bridge waits indefinitely. Then goes to RESP.
  - RESP: transmits 0x4B ("K") after a write, 4 rdata bytes MSB first after a read, or 0x3F after a bad command. Each byte starts the cycle after the previous stop bit ends. After the last stop bit completes, clear busy and go to IDLE.
- Timeout: in ADDR or DATA, a counter resets on each rx_valid. If it reaches TIMEOUT_BITS*CLK_DIV cycles with no byte, pulse err and return to IDLE with no bus access and no response.
- Overrun: a byte completed while in BUS or RESP is dropped and pulses err; the FSM is unaffected.
- TX engine: 10-bit frame (start 0, 8 data LSB first, stop 1), each bit held exactly CLK_DIV cycles. uart_tx is registered.
- Simultaneous events: if a timeout and an rx_valid fall in the same cycle, rx_valid wins and the counter resets. Multiple err causes in one cycle give a single pulse.
- The bus address is only 16 bits; the bridge does no alignment checking.

Test Plan (bench uses CLK_DIV=16, TIMEOUT_BITS=4):
- Write: host sends 57 00 10 DE AD BE EF; bus_ready=1 two cycles after bus_we rises -> bus_we high for exactly 3 cycles with bus_addr=0x0010 and bus_wdata=0xDEADBEEF; uart_tx then carries 0x4B; busy falls after its stop bit.
- Read: host sends 52 00 08; bus_rdata=0x12345678 with bus_ready in the same cycle bus_re rises -> bus_re high 1 cycle; uart_tx sends 12 34 56 78 back-to-back with no idle gap.
- Bad command: host sends 0x00 -> err pulses once, uart_tx sends 0x3F, no bus_we or bus_re.
- Timeout/recovery: host sends 57 00 then idles for 5 bit times -> err pulse, no bus access. A following 52 00 04 frame completes normally.
- Framing error and glitch: a byte with stop bit 0 -> err pulse and no response. A low pulse of 4 cycles on uart_rx -> ignored, no rx byte.
- Reset mid-operation: assert rst during the second response byte -> uart_tx=1 and busy=0 immediately. After release, a write frame works normally.
